// File: rtl/ap_ctrl_loop_sequencer.sv
// rtl/ap_ctrl_loop_sequencer.sv - ap_ctrl_hs sequencer splitting a length into burst and residual child runs
module ap_ctrl_loop_sequencer #(
    parameter int LEN_W      = 32,
    parameter int BURST_LOG2 = 4,
    parameter int CNT_W      = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ap_start,
    output logic                        ap_ready,
    output logic                        ap_done,
    output logic                        ap_idle,
    input  logic [LEN_W-1:0]            len,
    output logic                        burst_start,
    output logic [LEN_W-BURST_LOG2-1:0] burst_trips,
    input  logic                        burst_ready,
    input  logic                        burst_done,
    output logic                        resid_start,
    output logic [BURST_LOG2-1:0]       resid_trips,
    input  logic                        resid_ready,
    input  logic                        resid_done,
    output logic [CNT_W-1:0]            burst_cycles,
    output logic [CNT_W-1:0]            resid_cycles
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BURST_RUN = 2'd1,
        RESID_RUN = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                        state_q;
    logic                          armed_q;
    logic                          ap_done_q;
    logic                          burst_start_q;
    logic                          resid_start_q;
    logic [LEN_W-BURST_LOG2-1:0]   burst_trips_q;
    logic [BURST_LOG2-1:0]         resid_trips_q;
    logic [CNT_W-1:0]              burst_cycles_q;
    logic [CNT_W-1:0]              resid_cycles_q;
    logic [CNT_W-1:0]              burst_cycles_d;
    logic [CNT_W-1:0]              resid_cycles_d;
    logic [LEN_W-BURST_LOG2-1:0]   len_bursts;
    logic [BURST_LOG2-1:0]         len_resid;
    logic                          burst_exit;
    logic                          resid_exit;

    assign len_bursts = len[LEN_W-1:BURST_LOG2];
    assign len_resid  = len[BURST_LOG2-1:0];

    assign burst_cycles_d = (&burst_cycles_q) ? burst_cycles_q : burst_cycles_q + CNT_ONE;
    assign resid_cycles_d = (&resid_cycles_q) ? resid_cycles_q : resid_cycles_q + CNT_ONE;

    // A done only counts once the child has taken its start (ready now or earlier).
    assign burst_exit = burst_done && (!burst_start_q || burst_ready);
    assign resid_exit = resid_done && (!resid_start_q || resid_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            armed_q        <= 1'b0;
            ap_done_q      <= 1'b0;
            burst_start_q  <= 1'b0;
            resid_start_q  <= 1'b0;
            burst_trips_q  <= '0;
            resid_trips_q  <= '0;
            burst_cycles_q <= '0;
            resid_cycles_q <= '0;
        end else begin
            armed_q   <= 1'b1;
            ap_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (armed_q && ap_start) begin
                        burst_trips_q  <= len_bursts;
                        resid_trips_q  <= len_resid;
                        burst_cycles_q <= '0;
                        resid_cycles_q <= '0;
                        if (len_bursts != '0) begin
                            state_q       <= BURST_RUN;
                            burst_start_q <= 1'b1;
                        end else if (len_resid != '0) begin
                            state_q       <= RESID_RUN;
                            resid_start_q <= 1'b1;
                        end else begin
                            state_q   <= DONE;
                            ap_done_q <= 1'b1;
                        end
                    end
                end
                BURST_RUN: begin
                    burst_cycles_q <= burst_cycles_d;
                    if (burst_ready) begin
                        burst_start_q <= 1'b0;
                    end
                    if (burst_exit) begin
                        burst_start_q <= 1'b0;
                        if (resid_trips_q != '0) begin
                            state_q       <= RESID_RUN;
                            resid_start_q <= 1'b1;
                        end else begin
                            state_q   <= DONE;
                            ap_done_q <= 1'b1;
                        end
                    end
                end
                RESID_RUN: begin
                    resid_cycles_q <= resid_cycles_d;
                    if (resid_ready) begin
                        resid_start_q <= 1'b0;
                    end
                    if (resid_exit) begin
                        resid_start_q <= 1'b0;
                        state_q       <= DONE;
                        ap_done_q     <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Until the first edge after reset, ap_start is not trusted, so report idle.
    assign ap_idle      = (state_q == IDLE) && (!armed_q || !ap_start);
    assign ap_done      = ap_done_q;
    assign ap_ready     = ap_done_q;
    assign burst_start  = burst_start_q;
    assign resid_start  = resid_start_q;
    assign burst_trips  = burst_trips_q;
    assign resid_trips  = resid_trips_q;
    assign burst_cycles = burst_cycles_q;
    assign resid_cycles = resid_cycles_q;

endmodule
